// File: rtl/div_pkg.sv
// Shared types and sizing constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 16;
  localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/sub_step.sv
// Combinational ripple-borrow subtractor (a - b) built from generate/propagate
// terms, structured the same way as the companion ripple-carry adder.
module sub_step #(
  parameter int W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   bc;

  // A bit generates a borrow when a=0,b=1 and passes an incoming one when a==b.
  assign gen   = ~a_i & b_i;
  assign prop  = ~(a_i ^ b_i);
  assign bc[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_ripple
    assign diff_o[i] = a_i[i] ^ b_i[i] ^ bc[i];
    assign bc[i+1]   = gen[i] | (prop[i] & bc[i]);
  end

  assign borrow_o = bc[W];

endmodule

// File: rtl/seq_divider_16.sv
// Unsigned restoring divider producing one quotient bit per clock, with
// valid/ready request and response handshakes.
module seq_divider_16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int STEP_W = $clog2(WIDTH + 1);

  div_state_t        state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0]  dsr_q, dsr_d;
  logic [WIDTH:0]    prem_q, prem_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rout_q, rout_d;
  logic              dbz_q, dbz_d;

  logic              accept;
  logic              in_calc;
  logic              last_step;
  logic              dvd_msb;
  logic [WIDTH:0]    rem_in;
  logic [WIDTH-1:0]  dsr_in;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    trial;
  logic [WIDTH:0]    nrem;
  logic              borrow;
  logic              qbit;

  assign accept    = in_valid & in_ready;
  assign in_calc   = (state_q == CALC);
  assign last_step = in_calc && (cnt_q == STEP_W'(1));

  // The first step runs in the accept cycle straight from the operand inputs,
  // so the result lands WIDTH cycles after the accept instead of WIDTH+1.
  assign rem_in  = in_calc ? prem_q : '0;
  assign dvd_msb = in_calc ? dvd_q[WIDTH-1] : dividend[WIDTH-1];
  assign dsr_in  = in_calc ? dsr_q : divisor;
  assign shifted = (rem_in << 1) | {{WIDTH{1'b0}}, dvd_msb};

  sub_step #(.W(WIDTH + 1)) u_step (
    .a_i      (shifted),
    .b_i      ({1'b0, dsr_in}),
    .diff_o   (trial),
    .borrow_o (borrow)
  );

  assign qbit = ~borrow;
  assign nrem = borrow ? shifted : trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt_q == STEP_W'(1)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    prem_d = prem_q;
    quot_d = quot_q;
    rout_d = rout_q;
    dbz_d  = dbz_q;
    if (accept) begin
      dsr_d  = divisor;
      dvd_d  = {dividend[WIDTH-2:0], qbit};
      prem_d = nrem;
      cnt_d  = STEP_W'(WIDTH - 1);
      if (divisor == '0) begin
        quot_d = '1;
        rout_d = dividend;
        dbz_d  = 1'b1;
      end
    end else if (in_calc) begin
      dvd_d  = {dvd_q[WIDTH-2:0], qbit};
      prem_d = nrem;
      cnt_d  = cnt_q - STEP_W'(1);
      if (last_step) begin
        quot_d = {dvd_q[WIDTH-2:0], qbit};
        rout_d = nrem[WIDTH-1:0];
        dbz_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      prem_q <= '0;
      quot_q <= '0;
      rout_q <= '0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      prem_q <= prem_d;
      quot_q <= quot_d;
      rout_q <= rout_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rout_q;
  assign div_by_zero = dbz_q;

endmodule
